// File: rtl/dht11_scheduler.sv
// dht11_scheduler: owns the DHT11 controller start, merges periodic/one-shot requests, enforces the read gap,
// handles timeout/retry and holds the last good reading. Retry support is built when DHT11_SCHED_RETRY_EN is defined.
module dht11_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int MIN_GAP_MS = 1000,
  parameter int TIMEOUT_MS = 30,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req,
  output logic       sensor_start,
  output logic       sensor_rst,
  input  logic       sensor_done,
  input  logic       sensor_valid,
  input  logic [7:0] sensor_rh,
  input  logic [7:0] sensor_t,
  output logic [7:0] rh_out,
  output logic [7:0] t_out,
  output logic       data_valid,
  output logic       update,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       busy,
  output logic [2:0] state
);
  localparam logic [2:0] S_IDLE = 3'd0, S_GAP = 3'd1, S_START = 3'd2, S_WAIT = 3'd3, S_REC = 3'd4;
  localparam int DIV = CLK_HZ / 1000;
  localparam int MW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int PW  = PERIOD_MS > 1 ? $clog2(PERIOD_MS) : 1;
  localparam int GW  = MIN_GAP_MS > 0 ? $clog2(MIN_GAP_MS + 1) : 1;
  localparam int TW  = TIMEOUT_MS > 1 ? $clog2(TIMEOUT_MS) : 1;

  logic [MW-1:0] r_ms;
  logic [PW-1:0] r_per;
  logic [GW-1:0] r_gap;
  logic [TW-1:0] r_to;
  logic [2:0]    r_state, w_nxt;
  logic [7:0]    r_rh, r_t, r_err_cnt;
  logic          r_pending, r_start, r_srst, r_dv, r_upd, r_err, r_busy;
  logic          w_tick, w_per_exp, w_gap_ok, w_to, w_good, w_fail_final, w_retry, w_first;

  assign w_tick       = r_ms == MW'(DIV - 1);
  assign w_per_exp    = enable && w_tick && r_per == PW'(PERIOD_MS - 1);
  assign w_gap_ok     = r_gap == GW'(MIN_GAP_MS);
  assign w_to         = r_state == S_WAIT && w_tick && r_to == TW'(TIMEOUT_MS - 1);
  assign w_good       = r_state == S_WAIT && sensor_done && sensor_valid;
  assign w_fail_final = r_state == S_REC && !w_retry;

`ifdef DHT11_SCHED_RETRY_EN
  logic [2:0] r_att;
  assign w_retry = r_att < 3'(MAX_RETRY);
  assign w_first = r_att == 3'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_att <= 3'd0;
    else r_att <= r_state == S_IDLE ? 3'd0 : (r_state == S_REC && w_retry) ? r_att + 3'd1 : r_att;
  end
`else
  assign w_retry = 1'b0;
  assign w_first = 1'b1;
`endif

  always_comb begin
    w_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_nxt = r_pending ? S_GAP : S_IDLE;
      S_GAP:   w_nxt = w_gap_ok ? S_START : S_GAP;
      S_START: w_nxt = S_WAIT;
      S_WAIT:  w_nxt = sensor_done ? (sensor_valid ? S_IDLE : S_REC) : w_to ? S_REC : S_WAIT;
      S_REC:   w_nxt = w_retry ? S_GAP : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ms      <= '0;
      r_per     <= '0;
      r_gap     <= '0;
      r_to      <= '0;
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_start   <= 1'b0;
      r_srst    <= 1'b0;
      r_upd     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_dv      <= 1'b0;
      r_rh      <= 8'd0;
      r_t       <= 8'd0;
      r_err_cnt <= 8'd0;
    end else begin
      r_ms      <= w_tick ? '0 : r_ms + 1'b1;
      r_per     <= (!enable || w_per_exp) ? '0 : w_tick ? r_per + 1'b1 : r_per;
      r_gap     <= r_state == S_START ? '0 : (w_tick && !w_gap_ok) ? r_gap + 1'b1 : r_gap;
      r_to      <= r_state == S_START ? '0 : (r_state == S_WAIT && w_tick) ? r_to + 1'b1 : r_to;
      // a request landing on a retry's START must survive so it gets its own sequence
      r_pending <= req || w_per_exp || (r_pending && !(r_state == S_START && w_first));
      r_state   <= w_nxt;
      r_busy    <= w_nxt != S_IDLE;
      r_start   <= w_nxt == S_START;
      r_srst    <= w_to && !sensor_done;
      r_upd     <= w_good;
      r_err     <= w_fail_final;
      if (w_good) begin
        r_rh <= sensor_rh;
        r_t  <= sensor_t;
        r_dv <= 1'b1;
      end
      if (w_fail_final && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign sensor_start = r_start;
  assign sensor_rst   = r_srst;
  assign rh_out       = r_rh;
  assign t_out        = r_t;
  assign data_valid   = r_dv;
  assign update       = r_upd;
  assign err          = r_err;
  assign err_cnt      = r_err_cnt;
  assign busy         = r_busy;
  assign state        = r_state;
endmodule

// File: doc/dht11_scheduler.md
# dht11_scheduler

Sequencer that owns the `start` input of the DHT11 controller and decides when a measurement runs. It merges periodic and one-shot read requests and enforces the sensor's minimum inter-read gap. It retries failed or hung reads, resets a stuck controller, and holds the last good humidity/temperature pair for the UART/FND display paths.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency; `CLK_HZ/1000` must be an integer ≥ 1.
- `PERIOD_MS`, 2000, periodic read interval in ms.
- `MIN_GAP_MS`, 1000, minimum ms between consecutive `sensor_start` pulses, including retries.
- `TIMEOUT_MS`, 30, maximum ms from `sensor_start` to `sensor_done`.
- `MAX_RETRY`, 3, extra attempts after a failed read; range 0..7.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  periodic mode enable, level.
- `req`  in  1  one-shot read request, 1-cycle pulse (UART command).
- `sensor_start`  out  1  1-cycle start pulse to the controller.
- `sensor_rst`  out  1  1-cycle active-high reset to the controller on timeout.
- `sensor_done`  in  1  controller done pulse.
- `sensor_valid`  in  1  controller checksum-OK flag, sampled only with `sensor_done`.
- `sensor_rh`  in  8  controller humidity integer byte.
- `sensor_t`  in  8  controller temperature integer byte.
- `rh_out`  out  8  last good humidity.
- `t_out`  out  8  last good temperature.
- `data_valid`  out  1  sticky; set on the first good read.
- `update`  out  1  1-cycle pulse when `rh_out`/`t_out` are reloaded.
- `err`  out  1  1-cycle pulse when all attempts fail.
- `err_cnt`  out  8  failed-request count, saturates at 255.
- `busy`  out  1  high in every state except IDLE.
- `state`  out  3  current state encoding, for LEDs.

## Operation
- ms tick: a free-running counter from 0 to `CLK_HZ/1000-1`. `tick` asserts for one cycle on wrap.
- Period counter:
  - Counts ticks while `enable`=1 and clears while `enable`=0.
  - On reaching `PERIOD_MS` it sets `pending` and reloads 0.
- `req`=1 sets `pending`. `req` and period expiry in the same cycle set `pending` once, giving one read.
- A request arriving while busy stays pending and is serviced after the current cycle.
- Gap counter:
  - Counts ticks and saturates at `MIN_GAP_MS`; clears to 0 on every `sensor_start`.
  - Reset value is 0, so the first read occurs no earlier than `MIN_GAP_MS` after reset (sensor power-up settle).
- States: IDLE=0, GAP=1, START=2, WAIT_DONE=3, RECOVER=4.
  - IDLE: if `pending` → GAP; attempt counter ← 0.
  - GAP: when gap counter = `MIN_GAP_MS` → START.
  - START: `sensor_start`=1 for one cycle; clear `pending`; timeout counter ← 0; → WAIT_DONE.
  - WAIT_DONE:
    - `sensor_done`=1 with `sensor_valid`=1: load `rh_out`/`t_out`, pulse `update`, set `data_valid` → IDLE.
    - `sensor_done`=1 with `sensor_valid`=0: failure → RECOVER.
    - Timeout counter reaches `TIMEOUT_MS`: `sensor_rst`=1 for one cycle, failure → RECOVER.
    - If `sensor_done` and timeout occur in the same cycle, `sensor_done` wins.
  - RECOVER:
    - If attempts < `MAX_RETRY`: attempts+1 → GAP.
    - Otherwise: pulse `err`, `err_cnt`+1 (saturating) → IDLE.
- New requests arriving during a retry sequence set `pending` and start a fresh sequence after it ends.
- A failed read never modifies `rh_out`, `t_out` or `data_valid`.
- `sensor_done` outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - State IDLE; all counters 0; `pending`=0.
  - Outputs `sensor_start`, `sensor_rst`, `update`, `err`, `busy`, `data_valid` = 0.
  - `rh_out`, `t_out`, `err_cnt`, `state` = 0.
- All outputs are registered.
- Pending to START: 1 cycle IDLE→GAP, then GAP waits for the gap counter to saturate (0 extra cycles if already saturated). `sensor_start` is high on the cycle after GAP exits.
- Done to data: `rh_out`/`t_out`, `update` and `data_valid` change 1 cycle after the `sensor_done` sample. `busy` falls in the same cycle.
- Timeout resolution: 1 ms tick. `sensor_rst` pulses within 1 ms tick + 1 cycle of expiry.
- Reset asserted mid-read: everything returns to reset values immediately. The controller is reset externally by the same system reset.

## Configuration
- `DHT11_SCHED_RETRY_EN`
  - Defined: retry behaviour as above, `MAX_RETRY` honoured.
  - Undefined: the attempt counter is not built. RECOVER always takes the error branch, so the first failure pulses `err` and returns to IDLE; `MAX_RETRY` is ignored.

## Test plan
Bench uses `CLK_HZ`=1000 (1 tick/cycle), `MIN_GAP_MS`=10, `PERIOD_MS`=50, `TIMEOUT_MS`=20, `MAX_RETRY`=2.

- Reset release, then `req` at cycle 2 → `sensor_start` at cycle ≈12 (gap) → `sensor_done`+valid with rh=0x2D, t=0x19 → `rh_out`=0x2D, `t_out`=0x19, `update` 1 cycle, `data_valid`=1.
- `enable`=1 and `req` in the same cycle as period expiry → exactly one `sensor_start`; the next comes 50 ticks later.
- `sensor_valid`=0 on 3 consecutive dones → 3 starts spaced ≥10 ticks, then `err` 1 cycle, `err_cnt`=1, outputs unchanged.
- No `sensor_done` → `sensor_rst` pulse 20 ticks after each start. With the macro undefined, a single attempt then `err`.
- `req` during WAIT_DONE → serviced after completion; the second start is ≥10 ticks after the first.
- `rst` low during WAIT_DONE → `busy`=0, `state`=0, `sensor_start` stays low until a new request.
